product_accumulator: RTL

//  Downstream consumer of the 4x4 unsigned array multiplier's 8-bit product.

---
 rtl/product_accumulator.sv | 94 +++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums fixed-size groups of unsigned multiplier products into one result.
// Products arrive over a valid/ready handshake. Each finished group is held
// on a valid/ready output, together with a sticky carry-out flag, until the
// consumer takes it.

module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    // ACC_W must be at least PROD_W so that a single product fits in the sum
    localparam logic [3:0] CNT_LAST = 4'(COUNT - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [3:0]       cnt;
    logic             ovf;
    logic [ACC_W:0]   sum_ext;

    // One extra bit above the accumulator catches the carry out of ACC_W
    always_comb begin
        sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    end

    // Group FSM: accumulate products in ACCUM, then present the result in HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clr) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        if (cnt == CNT_LAST) begin
                            out_sum   <= sum_ext[ACC_W-1:0];
                            out_ovf   <= ovf | sum_ext[ACC_W];
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc <= sum_ext[ACC_W-1:0];
                            ovf <= ovf | sum_ext[ACC_W];
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
